// File: rtl/tile_sched_pkg.sv
// Shared types and constants for the tile tick scheduler: game-state encoding,
// lane LFSR seed/taps and datapath widths.
package tile_sched_pkg;

    localparam int PERIOD_W = 8;
    localparam int SCORE_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_OVER   = 2'd3
    } state_e;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // x^8+x^6+x^5+x^4+1, Fibonacci form: feedback is XOR of bits 7,5,4,3
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/tile_tick_scheduler_if.sv
// Control/status bundle between the input logic (master) and the tick scheduler (slave).
// Inputs are level/pulse signals; all scheduler outputs are registered.
interface tile_tick_scheduler_if;
    import tile_sched_pkg::*;

    logic                start;
    logic                pause_btn;
    logic                miss;
    logic                scroll_tick;
    logic                row_spawn;
    logic [1:0]          spawn_lane;
    logic [1:0]          state;
    logic [PERIOD_W-1:0] period;
    logic [SCORE_W-1:0]  rows_spawned;

    modport master (
        output start, pause_btn, miss,
        input  scroll_tick, row_spawn, spawn_lane, state, period, rows_spawned
    );

    modport slave (
        input  start, pause_btn, miss,
        output scroll_tick, row_spawn, spawn_lane, state, period, rows_spawned
    );

endinterface

// File: rtl/tile_tick_scheduler_mod_divider.sv
// Modulo-period counter: last_hit is the same-cycle wrap strobe, tick follows it one clock later.
// No backpressure; cnt_en freezes the count, cnt_clr restarts it from zero.
module mod_divider #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cnt_en,
    input  logic         cnt_clr,
    input  logic [W-1:0] period,
    output logic         last_hit,
    output logic         tick
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] cnt_q, cnt_d;
    logic         tick_q, tick_d;

    always_comb begin
        // >= keeps the counter bounded even if the period ever shrinks under it
        last_hit = cnt_en && !cnt_clr && (cnt_q >= (period - ONE));
        cnt_d    = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (last_hit) begin
            cnt_d = '0;
        end else if (cnt_en) begin
            cnt_d = cnt_q + ONE;
        end
        tick_d = last_hit;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/tile_tick_scheduler.sv
// Game-tempo controller: state FSM, tick divider, row spawn with LFSR lane, speed ramp.
// One-clock registered outputs; no backpressure, miss/pause/start act the cycle they are sampled.
module tile_tick_scheduler
    import tile_sched_pkg::*;
#(
    parameter int PERIOD_INIT   = 200,
    parameter int PERIOD_MIN    = 40,
    parameter int PERIOD_STEP   = 8,
    parameter int TICKS_PER_ROW = 16,
    parameter int RAMP_ROWS     = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    tile_tick_scheduler_if.slave   bus
);

    localparam logic [PERIOD_W-1:0] P_INIT   = PERIOD_W'(PERIOD_INIT);
    localparam logic [PERIOD_W-1:0] P_MIN    = PERIOD_W'(PERIOD_MIN);
    localparam logic [PERIOD_W:0]   P_STEP   = (PERIOD_W + 1)'(PERIOD_STEP);
    localparam logic [7:0]          ROW_LAST = 8'(TICKS_PER_ROW - 1);
    localparam logic [7:0]          RAMP_LAST = 8'(RAMP_ROWS - 1);
    localparam logic [SCORE_W-1:0]  SCORE_ONE = SCORE_W'(1);

    state_e              state_q, state_d;
    logic                pause_q, pause_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [7:0]          row_q, row_d;
    logic [7:0]          ramp_q, ramp_d;
    logic [7:0]          lfsr_q, lfsr_d;
    logic [SCORE_W-1:0]  rows_q, rows_d;
    logic                spawn_q, spawn_d;
    logic [1:0]          lane_q, lane_d;

    logic                pause_rise;
    logic                new_game;
    logic                run_go;
    logic                div_last;
    logic                div_tick;
    logic                spawn;
    logic [PERIOD_W:0]   period_diff;
    logic [PERIOD_W-1:0] period_ramp;

    mod_divider #(.W(PERIOD_W)) u_div (
        .clk      (clk),
        .reset    (reset),
        .cnt_en   (run_go),
        .cnt_clr  (new_game),
        .period   (period_q),
        .last_hit (div_last),
        .tick     (div_tick)
    );

    always_comb begin
        pause_rise = bus.pause_btn & ~pause_q;
        new_game   = bus.start && (state_q == ST_IDLE || state_q == ST_OVER);
        // miss and a pause edge both pre-empt the divider in the cycle they arrive
        run_go     = (state_q == ST_RUN) && !bus.miss && !pause_rise;
        spawn      = div_last && (row_q == ROW_LAST);

        period_diff = {1'b0, period_q} - P_STEP;
        period_ramp = (period_diff[PERIOD_W] || (period_diff[PERIOD_W-1:0] < P_MIN))
                      ? P_MIN : period_diff[PERIOD_W-1:0];

        state_d  = state_q;
        pause_d  = bus.pause_btn;
        period_d = period_q;
        row_d    = row_q;
        ramp_d   = ramp_q;
        lfsr_d   = lfsr_q;
        rows_d   = rows_q;
        spawn_d  = spawn;
        lane_d   = lane_q;

        case (state_q)
            ST_IDLE, ST_OVER: if (bus.start) state_d = ST_RUN;
            ST_RUN: begin
                if (bus.miss)       state_d = ST_OVER;
                else if (pause_rise) state_d = ST_PAUSED;
            end
            ST_PAUSED: begin
                if (bus.miss)       state_d = ST_OVER;
                else if (pause_rise) state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase

        if (new_game) begin
            period_d = P_INIT;
            row_d    = '0;
            ramp_d   = '0;
            rows_d   = '0;
            lfsr_d   = LFSR_SEED;
        end

        if (div_last) begin
            row_d = spawn ? 8'd0 : row_q + 8'd1;
        end

        if (spawn) begin
            lane_d = lfsr_q[1:0];
            lfsr_d = lfsr_next(lfsr_q);
            rows_d = (rows_q == '1) ? rows_q : rows_q + SCORE_ONE;
            if (ramp_q == RAMP_LAST) begin
                ramp_d   = '0;
                period_d = period_ramp;
            end else begin
                ramp_d = ramp_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            pause_q  <= 1'b0;
            period_q <= P_INIT;
            row_q    <= '0;
            ramp_q   <= '0;
            lfsr_q   <= LFSR_SEED;
            rows_q   <= '0;
            spawn_q  <= 1'b0;
            lane_q   <= '0;
        end else begin
            state_q  <= state_d;
            pause_q  <= pause_d;
            period_q <= period_d;
            row_q    <= row_d;
            ramp_q   <= ramp_d;
            lfsr_q   <= lfsr_d;
            rows_q   <= rows_d;
            spawn_q  <= spawn_d;
            lane_q   <= lane_d;
        end
    end

    assign bus.scroll_tick  = div_tick;
    assign bus.row_spawn    = spawn_q;
    assign bus.spawn_lane   = lane_q;
    assign bus.state        = state_q;
    assign bus.period       = period_q;
    assign bus.rows_spawned = rows_q;

endmodule

// File: tb/tb_tile_tick_scheduler.sv
// Directed bench for tile_tick_scheduler with a reduced tempo parameter set.
module tb_tile_tick_scheduler;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    int   cyc;

    tile_tick_scheduler_if bus();

    tile_tick_scheduler #(
        .PERIOD_INIT   (10),
        .PERIOD_MIN    (4),
        .PERIOD_STEP   (3),
        .TICKS_PER_ROW (4),
        .RAMP_ROWS     (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns the number of edges until scroll_tick is seen, or -1 on timeout.
    task automatic wait_tick(input int max_cyc, output int n);
        int  i;
        logic seen;
        n    = -1;
        i    = 0;
        seen = 1'b0;
        while (!seen && i < max_cyc) begin
            step();
            i++;
            if (bus.scroll_tick) begin
                seen = 1'b1;
                n    = i;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.pause_btn = 1'b0;
        bus.miss      = 1'b0;

        // Reset held, then idle with no stimulus
        repeat (3) step();
        check_eq("rst_state",  32'(bus.state), 0);
        check_eq("rst_period", 32'(bus.period), 10);
        check_eq("rst_rows",   32'(bus.rows_spawned), 0);
        check_eq("rst_lane",   32'(bus.spawn_lane), 0);
        reset = 1'b0;
        for (int k = 0; k < 30; k++) begin
            step();
            check_eq("idle_state", 32'(bus.state), 0);
            check_eq("idle_tick",  32'(bus.scroll_tick), 0);
            check_eq("idle_spawn", 32'(bus.row_spawn), 0);
        end
        check_eq("idle_period", 32'(bus.period), 10);

        // First game: ticks after edges 10,20,30,40, spawn on the 4th
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check_eq("start_state", 32'(bus.state), 1);
        for (int k = 1; k <= 40; k++) begin
            step();
            check_eq("g1_tick",  32'(bus.scroll_tick), (k % 10 == 0) ? 1 : 0);
            check_eq("g1_spawn", 32'(bus.row_spawn), (k == 40) ? 1 : 0);
        end
        check_eq("g1_lane",   32'(bus.spawn_lane), 1);
        check_eq("g1_rows",   32'(bus.rows_spawned), 1);
        check_eq("g1_period", 32'(bus.period), 10);

        // Ramp: spacing 10 through tick 8, 7 through tick 16, then 4
        for (int n = 5; n <= 24; n++) begin
            wait_tick(20, cyc);
            check_eq("ramp_spacing", 32'(cyc), (n <= 8) ? 10 : ((n <= 16) ? 7 : 4));
            check_eq("ramp_spawn",   32'(bus.row_spawn), (n % 4 == 0) ? 1 : 0);
            if (n % 4 == 0) begin
                check_eq("ramp_period", 32'(bus.period), (n >= 16) ? 4 : ((n >= 8) ? 7 : 10));
                check_eq("ramp_rows",   32'(bus.rows_spawned), 32'(n / 4));
            end
        end

        // Miss on the wrap edge (period 4): divider sits at 3 on the 4th edge
        repeat (3) begin
            step();
            check_eq("pre_miss_tick", 32'(bus.scroll_tick), 0);
        end
        bus.miss = 1'b1;
        step();
        bus.miss = 1'b0;
        check_eq("miss_state", 32'(bus.state), 3);
        check_eq("miss_tick",  32'(bus.scroll_tick), 0);
        check_eq("miss_spawn", 32'(bus.row_spawn), 0);
        check_eq("miss_rows",  32'(bus.rows_spawned), 6);
        for (int k = 0; k < 10; k++) begin
            step();
            check_eq("over_tick",  32'(bus.scroll_tick), 0);
            check_eq("over_state", 32'(bus.state), 3);
        end
        check_eq("over_period", 32'(bus.period), 4);
        check_eq("over_rows",   32'(bus.rows_spawned), 6);
        bus.pause_btn = 1'b1;
        step();
        check_eq("over_pause_ignored", 32'(bus.state), 3);
        bus.pause_btn = 1'b0;
        step();

        // start with miss in OVER: start wins, fresh game
        bus.start = 1'b1;
        bus.miss  = 1'b1;
        step();
        bus.start = 1'b0;
        bus.miss  = 1'b0;
        check_eq("restart_state",  32'(bus.state), 1);
        check_eq("restart_period", 32'(bus.period), 10);
        check_eq("restart_rows",   32'(bus.rows_spawned), 0);
        wait_tick(20, cyc);
        check_eq("restart_first_tick", 32'(cyc), 10);

        // Pause sampled on the 4th edge after the tick, held for 100 cycles
        repeat (3) begin
            step();
            check_eq("pre_pause_tick", 32'(bus.scroll_tick), 0);
        end
        bus.pause_btn = 1'b1;
        step();
        check_eq("pause_state", 32'(bus.state), 2);
        for (int k = 0; k < 100; k++) begin
            step();
            check_eq("paused_tick", 32'(bus.scroll_tick), 0);
        end
        check_eq("paused_hold_state", 32'(bus.state), 2);
        bus.pause_btn = 1'b0;
        repeat (5) step();
        check_eq("release_state", 32'(bus.state), 2);
        bus.pause_btn = 1'b1;
        step();
        check_eq("resume_state", 32'(bus.state), 1);
        wait_tick(20, cyc);
        check_eq("resume_tick_delay", 32'(cyc), 7);
        bus.pause_btn = 1'b0;
        wait_tick(20, cyc);
        check_eq("post_resume_spacing", 32'(cyc), 10);
        wait_tick(20, cyc);
        check_eq("g2_spawn_spacing", 32'(cyc), 10);
        check_eq("g2_spawn",         32'(bus.row_spawn), 1);
        check_eq("g2_lane",          32'(bus.spawn_lane), 1);
        check_eq("g2_rows",          32'(bus.rows_spawned), 1);

        // Async reset between edges while a spawn pulse is high
        #3;
        reset = 1'b1;
        #1;
        check_eq("arst_state", 32'(bus.state), 0);
        check_eq("arst_tick",  32'(bus.scroll_tick), 0);
        check_eq("arst_spawn", 32'(bus.row_spawn), 0);
        check_eq("arst_lane",  32'(bus.spawn_lane), 0);
        check_eq("arst_rows",  32'(bus.rows_spawned), 0);
        check_eq("arst_period", 32'(bus.period), 10);
        #2;
        reset = 1'b0;
        step();

        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check_eq("g3_state", 32'(bus.state), 1);
        for (int n = 1; n <= 4; n++) begin
            wait_tick(20, cyc);
            check_eq("g3_spacing", 32'(cyc), 10);
            check_eq("g3_spawn",   32'(bus.row_spawn), (n == 4) ? 1 : 0);
        end
        check_eq("g3_lane", 32'(bus.spawn_lane), 1);
        check_eq("g3_rows", 32'(bus.rows_spawned), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
